// File: rtl/nanorv32_useq_pkg.sv
// Shared state encoding and default urom layout for the nanorv32 micro-sequencer.
// The same start/length values are used when generating the nanorv32_urom contents.
package nanorv32_useq_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_IDLE = 2'd1,
    ST_ENT  = 2'd2,
    ST_EXT  = 2'd3
  } useq_state_t;

  localparam int unsigned USEQ_UROM_AW    = 5;
  localparam int unsigned USEQ_RST_START  = 0;
  localparam int unsigned USEQ_RST_LEN    = 2;
  localparam int unsigned USEQ_ENT_START  = 2;
  localparam int unsigned USEQ_ENT_LEN    = 16;
  localparam int unsigned USEQ_EXT_START  = 18;
  localparam int unsigned USEQ_EXT_LEN    = 2;

endpackage

// File: rtl/nanorv32_useq.sv
// Micro-sequencer feeding nanorv32_urom words to decode for reset, irq entry and irq exit.
// Optional: define NANORV32_USEQ_HANDLER_LOCK_EN to block nested irqs and stray irq returns.
module nanorv32_useq
  import nanorv32_useq_pkg::*;
#(
  parameter int unsigned UROM_AW   = USEQ_UROM_AW,
  parameter int unsigned RST_START = USEQ_RST_START,
  parameter int unsigned RST_LEN   = USEQ_RST_LEN,
  parameter int unsigned ENT_START = USEQ_ENT_START,
  parameter int unsigned ENT_LEN   = USEQ_ENT_LEN,
  parameter int unsigned EXT_START = USEQ_EXT_START,
  parameter int unsigned EXT_LEN   = USEQ_EXT_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               irq_req,
  input  logic               irq_en,
  input  logic               exit_req,
  output logic [UROM_AW-1:0] urom_addr,
  input  logic [31:0]        urom_dout,
  output logic [31:0]        instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               useq_active,
  output logic               irq_ack,
  output logic               seq_done
);

  localparam logic [UROM_AW-1:0] RST_BASE = UROM_AW'(RST_START);
  localparam logic [UROM_AW-1:0] ENT_BASE = UROM_AW'(ENT_START);
  localparam logic [UROM_AW-1:0] EXT_BASE = UROM_AW'(EXT_START);
  localparam logic [UROM_AW-1:0] RST_LAST = UROM_AW'(RST_LEN - 1);
  localparam logic [UROM_AW-1:0] ENT_LAST = UROM_AW'(ENT_LEN - 1);
  localparam logic [UROM_AW-1:0] EXT_LAST = UROM_AW'(EXT_LEN - 1);

  useq_state_t        state_q, state_d;
  logic [UROM_AW-1:0] idx_q, idx_d;
  logic               exit_pend_q, exit_pend_d;
  logic               irq_ack_q, irq_ack_d;
  logic               seq_done_q, seq_done_d;
  logic [UROM_AW-1:0] seq_base;
  logic [UROM_AW-1:0] seq_last;
  logic               exit_ok;
  logic               irq_ok;
  logic               accept;

`ifdef NANORV32_USEQ_HANDLER_LOCK_EN
  logic in_handler_q, in_handler_d;

  // Outside a handler an irq return has nothing to unwind, so it is discarded.
  assign exit_ok = exit_req & in_handler_q;
  assign irq_ok  = irq_req & irq_en & ~in_handler_q;
`else
  assign exit_ok = exit_req;
  assign irq_ok  = irq_req & irq_en;
`endif

  always_comb begin
    seq_base = RST_BASE;
    seq_last = RST_LAST;
    unique case (state_q)
      ST_RST:  begin seq_base = RST_BASE; seq_last = RST_LAST; end
      ST_IDLE: begin seq_base = RST_BASE; seq_last = RST_LAST; end
      ST_ENT:  begin seq_base = ENT_BASE; seq_last = ENT_LAST; end
      ST_EXT:  begin seq_base = EXT_BASE; seq_last = EXT_LAST; end
    endcase
  end

  // idx is held at 0 in IDLE, so IDLE presents RST_START on the urom bus.
  assign urom_addr   = seq_base + idx_q;
  assign instr       = urom_dout;
  assign instr_valid = (state_q != ST_IDLE);
  assign useq_active = instr_valid;
  assign irq_ack     = irq_ack_q;
  assign seq_done    = seq_done_q;
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    exit_pend_d = exit_pend_q;
    irq_ack_d   = 1'b0;
    seq_done_d  = 1'b0;
`ifdef NANORV32_USEQ_HANDLER_LOCK_EN
    in_handler_d = in_handler_q;
`endif
    if (state_q == ST_IDLE) begin
      // An irq return outranks a new irq; the irq is looked at again on the next IDLE.
      if (exit_pend_q | exit_ok) begin
        state_d     = ST_EXT;
        exit_pend_d = 1'b0;
      end else if (irq_ok) begin
        state_d   = ST_ENT;
        irq_ack_d = 1'b1;
      end
    end else begin
      if (exit_ok) exit_pend_d = 1'b1;
      if (accept) begin
        if (idx_q == seq_last) begin
          idx_d      = '0;
          state_d    = ST_IDLE;
          seq_done_d = 1'b1;
`ifdef NANORV32_USEQ_HANDLER_LOCK_EN
          if (state_q == ST_ENT) in_handler_d = 1'b1;
          if (state_q == ST_EXT) in_handler_d = 1'b0;
`endif
        end else begin
          idx_d = idx_q + UROM_AW'(1);
        end
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      idx_q       <= '0;
      exit_pend_q <= 1'b0;
      irq_ack_q   <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      exit_pend_q <= exit_pend_d;
      irq_ack_q   <= irq_ack_d;
      seq_done_q  <= seq_done_d;
    end
  end

`ifdef NANORV32_USEQ_HANDLER_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_handler_q <= 1'b0;
    else        in_handler_q <= in_handler_d;
  end
`endif

endmodule

// File: tb/tb_nanorv32_useq.sv
// Scoreboard bench for nanorv32_useq: directed scenarios followed by random traffic,
// checked against a queue-based model of the urom address streams.
module tb_nanorv32_useq;

  localparam int AW        = 5;
  localparam int RST_START = 0;
  localparam int RST_LEN   = 2;
  localparam int ENT_START = 2;
  localparam int ENT_LEN   = 16;
  localparam int EXT_START = 18;
  localparam int EXT_LEN   = 2;
`ifdef NANORV32_USEQ_HANDLER_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          irq_req, irq_en, exit_req, instr_ready;
  logic [AW-1:0] urom_addr;
  logic [31:0]   urom_dout, instr;
  logic          instr_valid, useq_active, irq_ack, seq_done;
  logic [31:0]   rom [32];

  int total = 0;
  int bad   = 0;

  // Model: addresses still to be delivered in the current sequence, plus the scoreboard.
  int burst[$];
  int exp_q[$];
  int m_kind;           // 0 reset, 1 entry, 2 exit
  bit m_pend, m_inh, m_ack, m_done;
  bit exp_valid, exp_ack, exp_done;
  int exp_addr;

  always #5 clk = ~clk;

  assign urom_dout = rom[urom_addr];

  nanorv32_useq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_req     (irq_req),
    .irq_en      (irq_en),
    .exit_req    (exit_req),
    .urom_addr   (urom_addr),
    .urom_dout   (urom_dout),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .useq_active (useq_active),
    .irq_ack     (irq_ack),
    .seq_done    (seq_done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_start(input int start, input int len, input int kind);
    for (int i = 0; i < len; i++) begin
      burst.push_back((start + i) % 32);
      exp_q.push_back((start + i) % 32);
    end
    m_kind = kind;
  endtask

  task automatic model_reset();
    burst.delete();
    exp_q.delete();
    m_pend = 0; m_inh = 0; m_ack = 0; m_done = 0;
    model_start(RST_START, RST_LEN, 0);
  endtask

  // What the sequencer does at one clock edge, given the inputs held across it.
  task automatic model_edge();
    bit ex_ok;
    ex_ok  = exit_req && (!LOCK || m_inh);
    m_ack  = 0;
    m_done = 0;
    if (burst.size() != 0) begin
      if (ex_ok) m_pend = 1;
      if (instr_ready) begin
        void'(burst.pop_front());
        if (burst.size() == 0) begin
          m_done = 1;
          if (m_kind == 1) m_inh = 1;
          if (m_kind == 2) m_inh = 0;
        end
      end
    end else if (m_pend || ex_ok) begin
      m_pend = 0;
      model_start(EXT_START, EXT_LEN, 2);
    end else if (irq_req && irq_en && !(LOCK && m_inh)) begin
      m_ack = 1;
      model_start(ENT_START, ENT_LEN, 1);
    end
  endtask

  task automatic set_exp();
    exp_valid = (burst.size() != 0);
    exp_addr  = exp_valid ? burst[0] : RST_START;
    exp_ack   = m_ack;
    exp_done  = m_done;
  endtask

  task automatic step(input bit r, input bit i, input bit e, input bit x, input bit rd);
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
    rst_n = r; irq_req = i; irq_en = e; exit_req = x; instr_ready = rd;
    if (!r) model_reset();
    set_exp();
  endtask

  task automatic run(input int n, input bit i, input bit rd);
    for (int k = 0; k < n; k++) step(1'b1, i, 1'b1, 1'b0, rd);
  endtask

  // Monitor: per-cycle control outputs, and one scoreboard pop per accepted word.
  always @(negedge clk) begin
    check("valid", {31'd0, instr_valid}, {31'd0, exp_valid});
    check("active", {31'd0, useq_active}, {31'd0, exp_valid});
    check("irq_ack", {31'd0, irq_ack}, {31'd0, exp_ack});
    check("seq_done", {31'd0, seq_done}, {31'd0, exp_done});
    check("addr", {27'd0, urom_addr}, exp_addr);
    check("instr_pass", instr, urom_dout);
    if (rst_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_accept", {27'd0, urom_addr}, 32'hffffffff);
      end else begin
        int a;
        a = exp_q.pop_front();
        check("acc_addr", {27'd0, urom_addr}, a);
        check("acc_instr", instr, rom[a]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    rom[1] = 32'h00000013;
    rom[2] = 32'hfe112e23;
    rst_n = 1'b0; irq_req = 1'b0; irq_en = 1'b0; exit_req = 1'b0; instr_ready = 1'b1;
    model_reset();
    set_exp();

    // Reset release with decode always ready.
    step(1'b0, 0, 0, 0, 1);
    run(4, 1'b0, 1'b1);
    // Decode stall mid reset sequence.
    step(1'b0, 0, 0, 0, 1);
    step(1'b1, 0, 0, 0, 1);
    run(3, 1'b0, 1'b0);
    run(3, 1'b0, 1'b1);
    // Plain interrupt entry.
    step(1'b1, 1, 1, 0, 1);
    run(20, 1'b0, 1'b1);
    // Exit and irq in the same IDLE cycle.
    step(1'b1, 1, 1, 1, 1);
    run(4, 1'b1, 1'b1);
    run(22, 1'b0, 1'b1);
    // Exit pulse while entry is running.
    step(1'b1, 1, 1, 0, 1);
    run(5, 1'b0, 1'b1);
    step(1'b1, 0, 1, 1, 1);
    run(20, 1'b0, 1'b1);
    // Reset in the middle of an entry routine.
    step(1'b1, 1, 1, 0, 1);
    run(9, 1'b0, 1'b1);
    step(1'b0, 0, 1, 0, 1);
    run(5, 1'b0, 1'b1);
    // Second irq while a handler is running, then the return.
    step(1'b1, 1, 1, 0, 1);
    run(22, 1'b1, 1'b1);
    step(1'b1, 1, 1, 1, 1);
    run(10, 1'b1, 1'b1);
    run(25, 1'b0, 1'b1);

    // Random traffic with stalls, pulses and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      bit r, i, e, x, rd;
      r  = ($urandom_range(0, 299) != 0);
      i  = ($urandom_range(0, 3) == 0);
      e  = ($urandom_range(0, 3) != 0);
      x  = ($urandom_range(0, 15) == 0);
      rd = ($urandom_range(0, 3) != 0);
      step(r, i, e, x, rd);
    end

    // Drain whatever sequence is in flight.
    run(40, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
